// File: rtl/decode_stage_hz.sv
// decode_stage_hz: RISC-V ID stage with a GPR file and write-back bypass, RV32I decode,
// an immediate generator, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_hz #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1,
  localparam int RN_W     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr,
  input  logic            wb_we,
  input  logic [RN_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_ex,
  output logic [XLEN-1:0] d1,
  output logic [XLEN-1:0] d2,
  output logic [XLEN-1:0] imm,
  output logic [RN_W-1:0] rs1_ex,
  output logic [RN_W-1:0] rs2_ex,
  output logic [RN_W-1:0] rd_ex,
  output logic [2:0]      funct3_ex,
  output logic            funct7b5_ex,
  output logic            alu_src_imm,
  output logic            mem_we,
  output logic            reg_we,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump,
  output logic            jalr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic alu_src_imm;
    logic mem_we;
    logic reg_we;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic jalr;
  } ctl_t;

  logic [XLEN-1:0] gpr [NREGS];
  logic [RN_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm_d;
  logic [31:0]     imm32, imm_i, imm_s, imm_b, imm_u, imm_j;
  ctl_t            ctl_d, ctl_q;
  logic            use_rs1, use_rs2, hz, issue;

  assign rs1 = instr[15 +: RN_W];
  assign rs2 = instr[20 +: RN_W];
  assign rd  = instr[7 +: RN_W];

  // x0 is never written, so it stays zero without a special read case in storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      gpr[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd1 = gpr[rs1];
    rd2 = gpr[rs2];
    if (WB_BYPASS && wb_we && wb_addr == rs1) rd1 = wb_data;
    if (WB_BYPASS && wb_we && wb_addr == rs2) rd2 = wb_data;
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctl_d   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    case (instr[6:0])
      OP_R: begin
        ctl_d.reg_we = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_IMM: begin
        ctl_d.reg_we      = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        use_rs1           = 1'b1;
        imm32             = imm_i;
      end
      OP_LOAD: begin
        ctl_d.reg_we      = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        ctl_d.mem_to_reg  = 1'b1;
        use_rs1           = 1'b1;
        imm32             = imm_i;
      end
      OP_STORE: begin
        ctl_d.mem_we      = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
        imm32             = imm_s;
      end
      OP_BRANCH: begin
        ctl_d.branch = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        imm32        = imm_b;
      end
      OP_JAL: begin
        ctl_d.reg_we = 1'b1;
        ctl_d.jump   = 1'b1;
        imm32        = imm_j;
      end
      OP_JALR: begin
        ctl_d.reg_we      = 1'b1;
        ctl_d.jump        = 1'b1;
        ctl_d.jalr        = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        use_rs1           = 1'b1;
        imm32             = imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        ctl_d.reg_we      = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        imm32             = imm_u;
      end
      default: ;
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));

  // A load sitting in EX whose destination feeds this instruction must wait one cycle
  assign hz = in_valid && out_valid && ctl_q.mem_to_reg && (rd_ex != '0) &&
              ((use_rs1 && rs1 == rd_ex) || (use_rs2 && rs2 == rd_ex));
  assign stall_out = hz || ex_stall;
  assign issue     = in_valid && !flush && !hz;

  // Flush outranks the downstream hold; data fields load on bubbles too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      ctl_q       <= '0;
      pc_ex       <= '0;
      d1          <= '0;
      d2          <= '0;
      imm         <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      funct3_ex   <= '0;
      funct7b5_ex <= 1'b0;
    end else if (flush || !ex_stall) begin
      out_valid   <= issue;
      ctl_q       <= issue ? ctl_d : '0;
      pc_ex       <= pc_in;
      d1          <= rd1;
      d2          <= rd2;
      imm         <= imm_d;
      rs1_ex      <= rs1;
      rs2_ex      <= rs2;
      rd_ex       <= rd;
      funct3_ex   <= instr[14:12];
      funct7b5_ex <= instr[30];
    end
  end

  assign alu_src_imm = ctl_q.alu_src_imm;
  assign mem_we      = ctl_q.mem_we;
  assign reg_we      = ctl_q.reg_we;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign branch      = ctl_q.branch;
  assign jump        = ctl_q.jump;
  assign jalr        = ctl_q.jalr;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: scoreboard bench for decode_stage_hz; stimulus pushes predicted ID/EX
// contents from a behavioural model and a monitor pops and compares them each cycle.
module tb_decode_stage_hz;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RN_W  = 5;

  localparam logic [6:0] ASI = 7'd64;
  localparam logic [6:0] MWE = 7'd32;
  localparam logic [6:0] RWE = 7'd16;
  localparam logic [6:0] M2R = 7'd8;
  localparam logic [6:0] BRN = 7'd4;
  localparam logic [6:0] JMP = 7'd2;
  localparam logic [6:0] JR  = 7'd1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, wb_we, ex_stall, flush;
  logic [XLEN-1:0] pc_in, wb_data;
  logic [31:0]     instr;
  logic [RN_W-1:0] wb_addr;
  logic            stall_out, out_valid, funct7b5_ex;
  logic [XLEN-1:0] pc_ex, d1, d2, imm;
  logic [RN_W-1:0] rs1_ex, rs2_ex, rd_ex;
  logic [2:0]      funct3_ex;
  logic            alu_src_imm, mem_we, reg_we, mem_to_reg, branch, jump, jalr;

  decode_stage_hz #(.XLEN(XLEN), .NREGS(NREGS), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instr(instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .pc_ex(pc_ex), .d1(d1), .d2(d2), .imm(imm),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
    .funct7b5_ex(funct7b5_ex), .alu_src_imm(alu_src_imm), .mem_we(mem_we), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jalr(jalr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [6:0]  ctl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
  } idex_t;

  idex_t       exp_q[$];
  idex_t       cur;
  logic [31:0] gpr_model [32];
  logic        last_stall;
  int          tests = 0;
  int          fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] ctl_of(input logic [6:0] op);
    case (op)
      7'h33:        return RWE;
      7'h13:        return RWE | ASI;
      7'h03:        return RWE | ASI | M2R;
      7'h23:        return MWE | ASI;
      7'h63:        return BRN;
      7'h6F:        return RWE | JMP;
      7'h67:        return RWE | JMP | JR | ASI;
      7'h37, 7'h17: return RWE | ASI;
      default:      return 7'd0;
    endcase
  endfunction

  function automatic logic [1:0] uses(input logic [6:0] op);
    case (op)
      7'h33, 7'h23, 7'h63: return 2'b11;
      7'h13, 7'h03, 7'h67: return 2'b10;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int s;
    s = int'(ins);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return s >>> 20;
      7'h23: return ((s >>> 25) <<< 5) | int'(ins[11:7]);
      7'h63: return ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) |
                    (int'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) |
                    (int'(ins[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return gpr_model[idx];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) gpr_model[i] = 32'd0;
    cur = '0;
    exp_q.delete();
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic stl, input logic fl);
    idex_t      nxt;
    logic [1:0] u;
    logic       hz;
    @(negedge clk);
    in_valid = v; pc_in = pc; instr = ins;
    wb_we = we; wb_addr = wa; wb_data = wd;
    ex_stall = stl; flush = fl;
    #1;
    u  = uses(ins[6:0]);
    hz = v && cur.valid && cur.ctl[3] && (cur.rd != 5'd0) &&
         ((u[1] && ins[19:15] == cur.rd) || (u[0] && ins[24:20] == cur.rd));
    last_stall = hz || stl;
    checkOutput("stall_out", 32'(stall_out), 32'(last_stall));
    nxt     = '0;
    nxt.pc  = pc;
    nxt.d1  = readReg(ins[19:15], we, wa, wd);
    nxt.d2  = readReg(ins[24:20], we, wa, wd);
    nxt.imm = imm_of(ins);
    nxt.rs1 = ins[19:15];
    nxt.rs2 = ins[24:20];
    nxt.rd  = ins[11:7];
    nxt.f3  = ins[14:12];
    nxt.f7  = ins[30];
    if (fl) begin
      nxt.valid = 1'b0;
      nxt.ctl   = 7'd0;
    end else if (stl) begin
      nxt = cur;
    end else if (hz) begin
      nxt.valid = 1'b0;
      nxt.ctl   = 7'd0;
    end else begin
      nxt.valid = v;
      nxt.ctl   = v ? ctl_of(ins[6:0]) : 7'd0;
    end
    exp_q.push_back(nxt);
    cur = nxt;
    if (we && wa != 5'd0) gpr_model[wa] = wd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] b;
    logic [6:0]  op;
    b = $urandom;
    case ($urandom_range(0, 10))
      0:       op = 7'h33;
      1:       op = 7'h13;
      2, 3:    op = 7'h03;
      4:       op = 7'h23;
      5:       op = 7'h63;
      6:       op = 7'h6F;
      7:       op = 7'h67;
      8:       op = 7'h37;
      9:       op = 7'h17;
      default: op = 7'h7F;
    endcase
    return {b[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), b[14:12],
            5'($urandom_range(0, 7)), op};
  endfunction

  // Monitor: every cycle out of reset, compare ID/EX against the oldest prediction
  initial begin
    idex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
          checkOutput("controls", 32'({alu_src_imm, mem_we, reg_we, mem_to_reg, branch, jump, jalr}),
                      32'(e.ctl));
          if (e.valid) begin
            checkOutput("pc_ex", pc_ex, e.pc);
            checkOutput("d1", d1, e.d1);
            checkOutput("d2", d2, e.d2);
            checkOutput("imm", imm, e.imm);
            checkOutput("rs1_ex", 32'(rs1_ex), 32'(e.rs1));
            checkOutput("rs2_ex", 32'(rs2_ex), 32'(e.rs2));
            checkOutput("rd_ex", 32'(rd_ex), 32'(e.rd));
            checkOutput("funct3_ex", 32'(funct3_ex), 32'(e.f3));
            checkOutput("funct7b5_ex", 32'(funct7b5_ex), 32'(e.f7));
          end
        end else begin
          checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r_ins, r_pc;
    logic        r_v, r_stl, r_fl;
    rst = 1'b0;
    in_valid = 1'b0; pc_in = '0; instr = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_stall = 1'b0; flush = 1'b0;
    last_stall = 1'b0;
    resetModel();
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_stall_out", 32'(stall_out), 32'd0);
    checkOutput("rst_pc_ex", pc_ex, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) idle();
    @(posedge clk); #2;
    checkOutput("idle_d1", d1, 32'd0);
    checkOutput("idle_imm", imm, 32'd0);
    checkOutput("idle_reg_we", 32'(reg_we), 32'd0);

    // Write-back bypass into rs1, then a write to x0 that must not stick
    applyStimulus(1'b1, 32'h100, 32'h000280B3, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("bypass_d1", d1, 32'hDEADBEEF);
    checkOutput("bypass_d2", d2, 32'd0);
    checkOutput("bypass_reg_we", 32'(reg_we), 32'd1);
    applyStimulus(1'b1, 32'h104, 32'h000000B3, 1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("x0_d1", d1, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 32'h0000_1000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0005, 1'b0, 1'b0);

    // Immediate formats
    applyStimulus(1'b1, 32'h108, 32'hFE20AE23, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("sw_imm", imm, 32'hFFFFFFFC);
    checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
    applyStimulus(1'b1, 32'h10C, 32'hFE000CE3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("beq_imm", imm, 32'hFFFFFFF8);
    checkOutput("beq_branch", 32'(branch), 32'd1);
    applyStimulus(1'b1, 32'h110, 32'h123452B7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("lui_imm", imm, 32'h12345000);
    applyStimulus(1'b1, 32'h114, 32'h001000EF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("jal_imm", imm, 32'h00000800);
    checkOutput("jal_jump", 32'(jump), 32'd1);

    // Load-use: lw x3 then add x4,x3,x2 stalls once
    applyStimulus(1'b1, 32'h120, 32'h0000A183, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h124, 32'h00218233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("lu_stall", 32'(stall_out), 32'd1);
    @(posedge clk); #2;
    checkOutput("lu_bubble_valid", 32'(out_valid), 32'd0);
    checkOutput("lu_bubble_reg_we", 32'(reg_we), 32'd0);
    applyStimulus(1'b1, 32'h124, 32'h00218233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("lu_stall_clear", 32'(stall_out), 32'd0);
    @(posedge clk); #2;
    checkOutput("lu_issue_valid", 32'(out_valid), 32'd1);
    checkOutput("lu_issue_rd", 32'(rd_ex), 32'd4);
    applyStimulus(1'b1, 32'h128, 32'h0000A183, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12C, 32'h00228233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("indep_no_stall", 32'(stall_out), 32'd0);
    applyStimulus(1'b1, 32'h130, 32'h0000A003, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h134, 32'h00200233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("x0_no_stall", 32'(stall_out), 32'd0);

    // Downstream hold for three cycles, then flush beating the hold
    applyStimulus(1'b1, 32'h200, 32'h000280B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h204 + 32'(k * 4), 32'h123452B7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      @(posedge clk); #2;
      checkOutput("hold_pc_ex", pc_ex, 32'h200);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b1, 32'h210, 32'h123452B7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    @(posedge clk); #2;
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_reg_we", 32'(reg_we), 32'd0);

    // Illegal opcode issues as a valid NOP
    applyStimulus(1'b1, 32'h300, 32'h0000007F, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("illegal_valid", 32'(out_valid), 32'd1);
    checkOutput("illegal_ctl", 32'({alu_src_imm, mem_we, reg_we, mem_to_reg, branch, jump, jalr}),
                32'd0);

    // Reset while a load-use hazard is active
    applyStimulus(1'b1, 32'h400, 32'h0000A183, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, 32'h00218233, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("pre_rst_stall", 32'(stall_out), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_stall", 32'(stall_out), 32'd0);
    checkOutput("midrst_m2r", 32'(mem_to_reg), 32'd0);
    checkOutput("midrst_pc_ex", pc_ex, 32'd0);
    resetModel();
    in_valid = 1'b0; instr = '0; pc_in = '0; wb_we = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h500, 32'h000280B3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checkOutput("gpr_cleared_d1", d1, 32'd0);

    // Randomised traffic; fetch holds the ID instruction while stall_out is high
    r_pc  = 32'h1000;
    r_ins = rand_instr();
    r_v   = 1'b1;
    for (int n = 0; n < 500; n++) begin
      r_stl = ($urandom_range(0, 9) == 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      applyStimulus(r_v, r_pc, r_ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom, r_stl, r_fl);
      if (r_fl || !last_stall) begin
        r_pc  = r_pc + 32'd4;
        r_ins = rand_instr();
        r_v   = ($urandom_range(0, 7) != 0);
      end
    end

    repeat (2) idle();
    @(posedge clk); #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
